multicore_mem_arbiter: RTL and testbench
========================================

# multicore_mem_arbiter

- Parametrised round-robin arbiter that lets NUM_CORES RV32I multicycle cores share one single-ported data memory.
- It is the next-generation multicore top's shared-bus element: each core instance owns one requester slot, indexed by its core ID minus 1.
- It accepts one request at a time, drives the memory for a fixed latency, and returns the response to the winning core only.
- Fairness is rotating; core 0 has first priority after reset.

## Interface
Parameters:
- NUM_CORES, 4, number of requesters (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_CORES  per-core request
- req_we  in  NUM_CORES  per-core write enable
- req_addr  in  NUM_CORES×ADDR_W  per-core address
- req_wdata  in  NUM_CORES×DATA_W  per-core write data
- req_ready  out  NUM_CORES  one-hot accept
- rsp_valid  out  NUM_CORES  one-hot response strobe
- rsp_rdata  out  DATA_W  response data, shared by all cores
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- grant_id  out  $clog2(NUM_CORES) (min 1)  index of the current or last winner
- stat_grants  out  NUM_CORES×32  per-core grant counts (see Configuration)
- stat_stall  out  32  contention cycles (see Configuration)

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE
  - Winner is the first core with req_valid set, scanning from ptr+1 upward modulo NUM_CORES.
  - req_ready[winner] is driven combinationally, only in IDLE.
  - On a handshake (req_valid & req_ready at the edge), latch we/addr/wdata and the winner, then go to ISSUE.
- ISSUE
  - mem_en=1 for exactly one cycle, with the latched fields on mem_*.
  - Load a wait counter with MEM_LAT-1, then go to WAIT.
- WAIT
  - Decrement the counter. At zero, capture mem_rdata (for writes, capture 0) and go to RESP.
- RESP
  - rsp_valid[winner]=1 for one cycle and rsp_rdata = captured value.
  - Set ptr ← winner, then go to IDLE.
- Requester rules:
  - A core holds req_valid and its fields stable until accepted.
  - A core issues no new request before its rsp_valid.
  - Requests that are not selected wait; they are never dropped.
- mem_* outputs are 0 whenever mem_en=0.
- NUM_CORES=1 degenerates to pass-through with the same timing.

## Timing
- Handshake at edge T → mem_en during cycle T+1 → rsp_valid during cycle T+2+MEM_LAT.
- Back-to-back throughput: one transaction per MEM_LAT+3 cycles.
- A req_valid that rises in the same cycle as RESP is considered on the next IDLE cycle. The ptr update has already taken effect there.
- Reset values:
  - state = IDLE, ptr = NUM_CORES-1, grant_id = 0
  - all req_ready, rsp_valid and mem_* = 0
  - rsp_rdata = 0, stat counters = 0
- Reset mid-transaction abandons the access: no rsp_valid, no mem_en afterward.

## Configuration
- MULTICORE_ARB_STATS_EN defined:
  - stat_grants[i] increments on each handshake of core i.
  - stat_stall increments every cycle in which some req_valid is high with no req_ready to that core.
  - Both counters saturate at 2^32-1.
- Undefined: stat_grants and stat_stall are tied to 0, and no counter logic is generated.

## Structure
- multicore_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP)
  - CORE_ID_W(n) function returning max(1, $clog2(n))
  - default constants NUM_CORES_DEF=4 and MEM_LAT_DEF=1
- Sub-module rr_pick: combinational round-robin selector, NUM_CORES req bits + ptr → one-hot grant + index. It is reused by the future instruction-memory arbiter.

## Test plan
- Single read: core 2 requests addr 0x40, memory returns 0xDEADBEEF, MEM_LAT=1 → req_ready[2] at T, mem_en at T+1, rsp_valid[2] with 0xDEADBEEF at T+3.
- All four cores request continuously after reset → grant order 0,1,2,3,0, with each rsp_valid 4 cycles apart.
- Core 1 write 0x55 to 0x10, then core 1 reads 0x10 → mem_we=1 with wdata 0x55, write response data 0, read returns 0x55.
- MEM_LAT=3 with core 3 alone → rsp_valid[3] exactly 5 cycles after the handshake edge.
- rst asserted during WAIT → all outputs 0 immediately, no rsp_valid, and after release core 0 wins first.
- With MULTICORE_ARB_STATS_EN, 8 full-contention rounds → stat_grants = 8 per core, stat_stall > 0. Without the macro, both are 0.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared types and helpers for the multicore memory arbiter and its round-robin selector.
package multicore_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam int NUM_CORES_DEF = 4;
    localparam int MEM_LAT_DEF   = 1;

    // Index width for n requesters, never narrower than one bit.
    function automatic int CORE_ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: grants the first set request after i_ptr,
// wrapping modulo NUM_CORES.
module rr_pick
    import multicore_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int IDX_W     = CORE_ID_W(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_CORES-1:0] o_gnt,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_CORES);
            if (!o_any && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                o_any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory among NUM_CORES cores.
// Define MULTICORE_ARB_STATS_EN to build the saturating grant/stall statistics counters.
module multicore_mem_arbiter
    import multicore_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = MEM_LAT_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            req_valid,
    input  logic [NUM_CORES-1:0]            req_we,
    input  logic [NUM_CORES*ADDR_W-1:0]     req_addr,
    input  logic [NUM_CORES*DATA_W-1:0]     req_wdata,
    output logic [NUM_CORES-1:0]            req_ready,
    output logic [NUM_CORES-1:0]            rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [CORE_ID_W(NUM_CORES)-1:0] grant_id,
    output logic [NUM_CORES*32-1:0]         stat_grants,
    output logic [31:0]                     stat_stall
);

    localparam int IDX_W = CORE_ID_W(NUM_CORES);
    localparam int CNT_W = CORE_ID_W(MEM_LAT);

    arb_state_t          r_state, w_state_nx;
    logic [IDX_W-1:0]    r_ptr, r_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [CNT_W-1:0]    r_cnt;

    logic [NUM_CORES-1:0] w_gnt;
    logic [IDX_W-1:0]     w_win;
    logic                 w_any, w_hs, w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_win),
        .o_any (w_any)
    );

    // The picker only grants a core whose req_valid is set, so any grant in IDLE is a handshake.
    assign w_hs     = (r_state == IDLE) && w_any;
    assign w_sel_we = |(req_we & w_gnt);

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (w_hs) w_state_nx = ISSUE;
            ISSUE:   w_state_nx = WAIT;
            WAIT:    if (r_cnt == '0) w_state_nx = RESP;
            RESP:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= IDX_W'(NUM_CORES - 1);
            r_grant <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_grant <= w_win;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                    end
                end
                ISSUE: r_cnt <= CNT_W'(MEM_LAT - 1);
                WAIT: begin
                    if (r_cnt == '0) r_rdata <= r_we ? '0 : mem_rdata;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                RESP:    r_ptr <= r_grant;
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE) ? w_gnt : '0;
    assign rsp_valid = (r_state == RESP) ? (NUM_CORES'(1) << r_grant) : '0;
    assign rsp_rdata = r_rdata;
    assign grant_id  = r_grant;

    // Memory bus is held at zero outside the single ISSUE cycle.
    assign mem_en    = (r_state == ISSUE);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = mem_en ? r_addr : '0;
    assign mem_wdata = mem_en ? r_wdata : '0;

`ifdef MULTICORE_ARB_STATS_EN
    logic [NUM_CORES*32-1:0] r_stat_grants;
    logic [31:0]             r_stat_stall;
    logic                    w_stall;

    assign w_stall = |(req_valid & ~req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_grants <= '0;
            r_stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_hs && w_gnt[i] && (r_stat_grants[i*32 +: 32] != '1)) begin
                    r_stat_grants[i*32 +: 32] <= r_stat_grants[i*32 +: 32] + 32'd1;
                end
            end
            if (w_stall && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_grants = r_stat_grants;
    assign stat_stall  = r_stat_stall;
`else
    assign stat_grants = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Scoreboard bench for multicore_mem_arbiter: a MEM_LAT=1 instance under a cycle model and a
// MEM_LAT=3 instance for latency checks.
module tb_multicore_mem_arbiter;

    localparam int NC  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 1;

    typedef struct {
        int          core;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          core;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NC-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [NC*AW-1:0] req_addr;
    logic [NC*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata, mem_rdata, mem_wdata;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [1:0]       grant_id;
    logic [NC*32-1:0] stat_grants;
    logic [31:0]      stat_stall;

    logic [NC-1:0]    req_valid3, req_we3, req_ready3, rsp_valid3;
    logic [NC*AW-1:0] req_addr3;
    logic [NC*DW-1:0] req_wdata3;
    logic [DW-1:0]    rsp_rdata3, mem_rdata3, mem_wdata3;
    logic             mem_en3, mem_we3;
    logic [AW-1:0]    mem_addr3;
    logic [1:0]       grant_id3;
    logic [NC*32-1:0] stat_grants3;
    logic [31:0]      stat_stall3;

    multicore_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_id(grant_id),
        .stat_grants(stat_grants), .stat_stall(stat_stall)
    );

    multicore_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_we(req_we3), .req_addr(req_addr3),
        .req_wdata(req_wdata3), .req_ready(req_ready3), .rsp_valid(rsp_valid3),
        .rsp_rdata(rsp_rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .grant_id(grant_id3),
        .stat_grants(stat_grants3), .stat_stall(stat_stall3)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
    endfunction

    // Memory devices: one-cycle RAM for dut, three-stage read pipeline for dut3.
    logic [31:0]  dev_mem [0:255];
    logic [255:0] dev_wr = '0;
    logic [31:0]  rd_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                dev_mem[mem_addr[9:2]] <= mem_wdata;
                dev_wr[mem_addr[9:2]]  <= 1'b1;
            end
            rd_q <= dev_wr[mem_addr[9:2]] ? dev_mem[mem_addr[9:2]] : init_word(mem_addr);
        end
    end
    assign mem_rdata = rd_q;

    logic [31:0] p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        p3_0 <= mem_en3 ? init_word(mem_addr3) : 32'h0;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign mem_rdata3 = p3_2;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bench model state
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    req_t        pend_q[$];
    exp_t        sb_q[$];
    int          order_q[$], hs_cyc_q[$], rsp_cyc_q[$];
    logic [31:0] rsp_dat_q[$];
    logic [31:0] model_mem [int];
    int          outstanding [NC];
    int          model_grants [NC];
    int          busy = 0;
    int          hs_cyc = 0;
    int          ptr_m = NC - 1;
    req_t        lat;

    function automatic int find_pend(input int c);
        for (int i = 0; i < pend_q.size(); i++) if (pend_q[i].core == c) return i;
        return -1;
    endfunction

    // Requesters: each core presents its oldest pending request when it has nothing in flight.
    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NC; c++) begin
                int i;
                i = find_pend(c);
                if (rst == 1'b0 && i >= 0 && outstanding[c] == 0) begin
                    req_valid[c]             = 1'b1;
                    req_we[c]                = pend_q[i].we;
                    req_addr[c*AW +: AW]     = pend_q[i].addr;
                    req_wdata[c*DW +: DW]    = pend_q[i].wdata;
                end else begin
                    req_valid[c]             = 1'b0;
                    req_we[c]                = 1'b0;
                    req_addr[c*AW +: AW]     = '0;
                    req_wdata[c*DW +: DW]    = '0;
                end
            end
        end
    end

    // Cycle monitor: predicts ready/mem/rsp each cycle and scores responses.
    logic [NC-1:0] m_ready;
    int            m_win, m_idx;
    logic          m_men, m_rsp;
    exp_t          m_exp;
    req_t          m_req;
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                m_ready = '0;
                m_win   = -1;
                if (busy == 0) begin
                    for (int k = 1; k <= NC; k++) begin
                        if (m_win < 0 && req_valid[(ptr_m + k) % NC]) m_win = (ptr_m + k) % NC;
                    end
                end
                if (m_win >= 0) m_ready[m_win] = 1'b1;
                check("req_ready", req_ready, m_ready);

                m_men = (busy != 0) && (cyc == hs_cyc + 1);
                check("mem_en", mem_en, m_men);
                if (m_men) begin
                    check("mem_we", mem_we, lat.we);
                    check("mem_addr", mem_addr, lat.addr);
                    check("mem_wdata", mem_wdata, lat.wdata);
                end else begin
                    check("mem_idle_ctl", {mem_we, mem_addr}, 0);
                    check("mem_idle_wdata", mem_wdata, 0);
                end

                m_rsp = (busy != 0) && (cyc == hs_cyc + 2 + LAT);
                if (m_rsp) begin
                    m_exp = sb_q.pop_front();
                    check("rsp_valid", rsp_valid, 4'(1) << m_exp.core);
                    check("rsp_rdata", rsp_rdata, m_exp.data);
                    check("grant_id", grant_id, m_exp.core);
                    rsp_cyc_q.push_back(cyc);
                    rsp_dat_q.push_back(rsp_rdata);
                    ptr_m                    = m_exp.core;
                    outstanding[m_exp.core]  = 0;
                    busy                     = 0;
                end else begin
                    check("rsp_valid_idle", rsp_valid, 0);
                end

                if (m_win >= 0) begin
                    m_idx = find_pend(m_win);
                    if (m_idx >= 0) begin
                        m_req = pend_q[m_idx];
                        pend_q.delete(m_idx);
                        m_exp.core = m_win;
                        if (m_req.we) m_exp.data = 32'h0;
                        else if (model_mem.exists(int'(m_req.addr)))
                            m_exp.data = model_mem[int'(m_req.addr)];
                        else m_exp.data = init_word(m_req.addr);
                        if (m_req.we) model_mem[int'(m_req.addr)] = m_req.wdata;
                        sb_q.push_back(m_exp);
                        lat                  = m_req;
                        busy                 = 1;
                        hs_cyc               = cyc;
                        outstanding[m_win]   = 1;
                        model_grants[m_win]  = model_grants[m_win] + 1;
                        order_q.push_back(m_win);
                        hs_cyc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic push_req(input int c, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
        req_t r;
        r.core = c; r.we = we; r.addr = a; r.wdata = d;
        pend_q.push_back(r);
    endtask

    task automatic clear_logs();
        order_q.delete(); hs_cyc_q.delete(); rsp_cyc_q.delete(); rsp_dat_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((pend_q.size() != 0 || busy != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 1000, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stats(input string tag);
        for (int c = 0; c < NC; c++) begin
`ifdef MULTICORE_ARB_STATS_EN
            check({tag, "_grants"}, stat_grants[c*32 +: 32], model_grants[c]);
`else
            check({tag, "_grants"}, stat_grants[c*32 +: 32], 0);
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n, d;
    initial begin
        rst        = 1'b1;
        req_valid3 = '0; req_we3 = '0; req_addr3 = '0; req_wdata3 = '0;
        for (int c = 0; c < NC; c++) begin outstanding[c] = 0; model_grants[c] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem", {mem_en, mem_we, mem_addr}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_stall", stat_stall, 0);
        check("rst_grants", stat_grants[63:0], 0);
        check("rst3_mem_en", mem_en3, 0);
        @(posedge clk); #2 rst = 1'b0;

        // Full contention: 8 rounds from all four cores
        clear_logs();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < NC; c++) push_req(c, 1'b0, 32'h100 + c * 32'h20 + r * 4, 32'h0);
        wait_idle("contention_done");
        check("contention_count", order_q.size(), 32);
        for (int i = 0; i < order_q.size(); i++) check("rr_order", order_q[i], i % NC);
        for (int i = 1; i < rsp_cyc_q.size(); i++)
            check("rsp_spacing", rsp_cyc_q[i] - rsp_cyc_q[i-1], 4);
`ifdef MULTICORE_ARB_STATS_EN
        for (int c = 0; c < NC; c++) check("stat_grants_8", stat_grants[c*32 +: 32], 8);
        check("stat_stall_nz", stat_stall != 0, 1'b1);
`else
        for (int c = 0; c < NC; c++) check("stat_grants_off", stat_grants[c*32 +: 32], 0);
        check("stat_stall_off", stat_stall, 0);
`endif

        // Single read by core 2
        clear_logs();
        push_req(2, 1'b0, 32'h40, 32'h0);
        wait_idle("single_done");
        check("single_winner", order_q[0], 2);
        check("single_data", rsp_dat_q[0], 32'hDEADBEEF);
        check("single_latency", rsp_cyc_q[0] - hs_cyc_q[0], 3);

        // Write then read back by core 1
        clear_logs();
        push_req(1, 1'b1, 32'h10, 32'h55);
        push_req(1, 1'b0, 32'h10, 32'h0);
        wait_idle("wr_rd_done");
        check("wr_rsp_data", rsp_dat_q[0], 0);
        check("rd_rsp_data", rsp_dat_q[1], 32'h55);

        // MEM_LAT=3 instance, core 3 alone
        @(posedge clk); #1;
        req_valid3 = 4'b1000;
        req_addr3[3*AW +: AW] = 32'h40;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready3[3] && n < 20);
        check("lat3_accept", req_ready3, 4'b1000);
        @(posedge clk); #1;
        req_valid3 = '0;
        req_addr3  = '0;
        @(negedge clk);
        check("lat3_mem_en", mem_en3, 1'b1);
        check("lat3_mem_addr", mem_addr3, 32'h40);
        d = 1;
        while (rsp_valid3 == 0 && d < 20) begin @(negedge clk); d++; end
        check("lat3_delay", d, 5);
        check("lat3_rsp_valid", rsp_valid3, 4'b1000);
        check("lat3_rsp_data", rsp_rdata3, 32'hDEADBEEF);

        // Reset while the arbiter sits in WAIT
        clear_logs();
        push_req(2, 1'b0, 32'h44, 32'h0);
        n = 0;
        while ((hs_cyc_q.size() == 0 || cyc != hs_cyc_q[0] + 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_reach_wait", n < 50, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_mem", {mem_en, mem_we, mem_addr}, 0);
        check("mid_rst_rsp_rdata", rsp_rdata, 0);
        check("mid_rst_grant_id", grant_id, 0);
        check("mid_rst_ready", req_ready, 0);
        check_stats("mid_rst");
        check("mid_rst_stall", stat_stall, 0);
        busy = 0; ptr_m = NC - 1;
        sb_q.delete(); pend_q.delete(); clear_logs();
        for (int c = 0; c < NC; c++) begin outstanding[c] = 0; model_grants[c] = 0; end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_no_rsp", rsp_cyc_q.size(), 0);
        push_req(2, 1'b0, 32'h48, 32'h0);
        push_req(0, 1'b0, 32'h4C, 32'h0);
        wait_idle("post_rst_done");
        check("post_rst_first", order_q[0], 0);
        check("post_rst_second", order_q[1], 2);
        check_stats("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
